// File: rtl/pwm_gen_pkg.sv
// Shared constants and state encodings for the PWM generator and its
// per-mille divider.
package pwm_gen_pkg;

   localparam int DEN        = 1000;
   localparam int DUTY_W     = 10;
   localparam int MIN_PERIOD = 2;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   typedef enum logic {
      STOP = 1'b0,
      RUN  = 1'b1
   } out_state_e;

endpackage

// File: rtl/pwm_gen_permil_div.sv
// Restoring sequential divider by the fixed per-mille denominator.
// One quotient bit per cycle; quotient bits shift into the dividend register.
module permil_div
   import pwm_gen_pkg::*;
#(
   parameter int PW = 42
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic [PW-1:0] dividend_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [PW-1:0] quot_o
);

   localparam int BW = $clog2(PW);
   localparam logic [DUTY_W:0] DEN_V = (DUTY_W + 1)'(DEN);

   div_state_e        state_q, state_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [DUTY_W-1:0] rem_q, rem_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DUTY_W:0]   trial_s;

   // Divider state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DIV_IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         bit_q   <= bit_d;
      end
   end

   // Next-state logic; the remainder stays below DEN so it fits DUTY_W bits
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      bit_d   = bit_q;
      trial_s = {rem_q, acc_q[PW-1]};
      case (state_q)
         DIV_IDLE: begin
            if (start_i) begin
               acc_d   = dividend_i;
               rem_d   = '0;
               bit_d   = BW'(PW - 1);
               state_d = DIV_RUN;
            end else begin
               state_d = DIV_IDLE;
            end
         end
         DIV_RUN: begin
            if (trial_s >= DEN_V) begin
               rem_d = DUTY_W'(trial_s - DEN_V);
               acc_d = {acc_q[PW-2:0], 1'b1};
            end else begin
               rem_d = trial_s[DUTY_W-1:0];
               acc_d = {acc_q[PW-2:0], 1'b0};
            end
            if (bit_q == '0) begin
               state_d = DIV_DONE;
            end else begin
               bit_d = bit_q - BW'(1);
            end
         end
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   assign busy_o = (state_q != DIV_IDLE);
   assign done_o = (state_q == DIV_DONE);
   assign quot_o = acc_q;

endmodule

// File: rtl/pwm_gen.sv
// Programmable PWM source: sanitises period/duty, computes the high-time with
// permil_div and swaps configurations only at period boundaries.
module pwm_gen
   import pwm_gen_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              load,
   input  logic [CNT_W-1:0]  period_in,
   input  logic [DUTY_W-1:0] duty_in,
   output logic              pwm_out,
   output logic              busy,
   output logic              cfg_pending,
   output logic              period_start,
   output logic [CNT_W-1:0]  high_cnt
);

   localparam int PW = CNT_W + DUTY_W;

   out_state_e       out_state_q, out_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_period_q, act_period_d, act_hc_q, act_hc_d;
   logic [CNT_W-1:0] pend_period_q, pend_period_d, pend_hc_q, pend_hc_d;
   logic [CNT_W-1:0] div_period_q;
   logic             cfg_pending_q, cfg_pending_d;
   logic             pwm_q, pwm_d, pstart_q, pstart_d;

   logic [CNT_W-1:0]  period_clamp_s, eff_period_s, eff_hc_s;
   logic [DUTY_W-1:0] duty_clamp_s;
   logic [PW-1:0]     product_s, quot_s;
   logic              start_s, div_busy_s, div_done_s, apply_s;

   assign period_clamp_s = (period_in < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_in;
   assign duty_clamp_s   = (duty_in > DUTY_W'(DEN)) ? DUTY_W'(DEN) : duty_in;
   assign product_s      = PW'(period_clamp_s) * PW'(duty_clamp_s);
   assign start_s        = load & ~div_busy_s;

   permil_div #(.PW(PW)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_s),
      .dividend_i (product_s),
      .busy_o     (div_busy_s),
      .done_o     (div_done_s),
      .quot_o     (quot_s)
   );

   // Output FSM, active/pending configuration and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_state_q   <= STOP;
         cnt_q         <= '0;
         act_period_q  <= CNT_W'(MIN_PERIOD);
         act_hc_q      <= '0;
         pend_period_q <= '0;
         pend_hc_q     <= '0;
         div_period_q  <= '0;
         cfg_pending_q <= 1'b0;
         pwm_q         <= 1'b0;
         pstart_q      <= 1'b0;
      end else begin
         out_state_q   <= out_state_d;
         cnt_q         <= cnt_d;
         act_period_q  <= act_period_d;
         act_hc_q      <= act_hc_d;
         pend_period_q <= pend_period_d;
         pend_hc_q     <= pend_hc_d;
         div_period_q  <= start_s ? period_clamp_s : div_period_q;
         cfg_pending_q <= cfg_pending_d;
         pwm_q         <= pwm_d;
         pstart_q      <= pstart_d;
      end
   end

   // A pending config is used already on the boundary cycle that applies it
   assign apply_s      = cfg_pending_q & ((out_state_q == STOP) | (cnt_q == '0));
   assign eff_period_s = apply_s ? pend_period_q : act_period_q;
   assign eff_hc_s     = apply_s ? pend_hc_q : act_hc_q;

   // Next-state logic; a finishing divide is recorded after the apply decision
   always_comb begin
      out_state_d   = out_state_q;
      cnt_d         = cnt_q;
      act_period_d  = act_period_q;
      act_hc_d      = act_hc_q;
      pend_period_d = pend_period_q;
      pend_hc_d     = pend_hc_q;
      cfg_pending_d = cfg_pending_q;
      pwm_d         = 1'b0;
      pstart_d      = 1'b0;
      if (apply_s) begin
         act_period_d  = pend_period_q;
         act_hc_d      = pend_hc_q;
         cfg_pending_d = 1'b0;
      end else begin
         cfg_pending_d = cfg_pending_q;
      end
      case (out_state_q)
         STOP: begin
            cnt_d = '0;
            if (enable) begin
               out_state_d = RUN;
               pstart_d    = 1'b1;
            end else begin
               out_state_d = STOP;
            end
         end
         RUN: begin
            if (!enable) begin
               out_state_d = STOP;
               cnt_d       = '0;
            end else begin
               pwm_d = (cnt_q < eff_hc_s);
               if (cnt_q >= eff_period_s - CNT_W'(1)) begin
                  cnt_d    = '0;
                  pstart_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: out_state_d = STOP;
      endcase
      if (div_done_s) begin
         pend_period_d = div_period_q;
         pend_hc_d     = quot_s[CNT_W-1:0];
         cfg_pending_d = 1'b1;
      end else begin
         pend_period_d = pend_period_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign busy         = div_busy_s;
   assign cfg_pending  = cfg_pending_q;
   assign period_start = pstart_q;
   assign high_cnt     = act_hc_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: directed scenarios plus randomized
// period/duty settings checked against an arithmetic reference.
module tb_pwm_gen;

   localparam int CNT_W = 32;
   localparam int PW    = CNT_W + 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              load = 1'b0;
   logic [CNT_W-1:0]  period_in = '0;
   logic [9:0]        duty_in = '0;
   logic              pwm_out, busy, cfg_pending, period_start;
   logic [CNT_W-1:0]  high_cnt;

   int n_checks = 0;
   int n_err    = 0;

   pwm_gen #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .load         (load),
      .period_in    (period_in),
      .duty_in      (duty_in),
      .pwm_out      (pwm_out),
      .busy         (busy),
      .cfg_pending  (cfg_pending),
      .period_start (period_start),
      .high_cnt     (high_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference high time: sanitise, then floor(period*duty/1000)
   function automatic longint ref_hc(input longint p, input longint d);
      longint pe, de;
      pe = (p < 2) ? 2 : p;
      de = (d > 1000) ? 1000 : d;
      return (pe * de) / 1000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int p, input int d, input string tag);
      int lat;
      period_in = p;
      duty_in   = d[9:0];
      load      = 1'b1;
      tick();
      load = 1'b0;
      check_eq({tag, "_busy"}, busy, 1);
      lat = 0;
      while (!cfg_pending && lat < 200) begin
         tick();
         lat++;
      end
      check_eq({tag, "_lat"}, lat, PW + 1);
      check_eq({tag, "_busy_done"}, busy, 0);
   endtask

   // Sync to a period start, then sample one whole period of the waveform
   task automatic measure(input int p, input int hc, input string tag);
      int w, highs, bad;
      w = 0;
      while (!period_start && w < 2100) begin
         tick();
         w++;
      end
      check_eq({tag, "_sync"}, period_start, 1);
      highs = 0;
      bad   = 0;
      for (int i = 0; i < p; i++) begin
         tick();
         if (pwm_out) highs++;
         if (pwm_out !== (i < hc)) bad++;
         if (period_start !== (i == p - 1)) bad++;
      end
      check_eq({tag, "_high"}, highs, hc);
      check_eq({tag, "_shape"}, bad, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int highs, bad, w, p, d;
      longint hc;

      #23;
      check_eq("rst_pwm", pwm_out, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_pend", cfg_pending, 0);
      check_eq("rst_pstart", period_start, 0);
      check_eq("rst_hcnt", high_cnt, 0);
      rst_n = 1'b1;
      tick();

      // 1000 / 250 from STOP
      do_load(1000, 250, "t1");
      tick();
      check_eq("t1_hcnt", high_cnt, 250);
      check_eq("t1_pend_clr", cfg_pending, 0);
      enable = 1'b1;
      measure(1000, 250, "t1a");
      measure(1000, 250, "t1b");

      // duty extremes at period 100, changed while running
      do_load(100, 0, "t2z");
      measure(100, 0, "t2z");
      check_eq("t2z_hcnt", high_cnt, 0);
      do_load(100, 1000, "t2f");
      measure(100, 100, "t2f");
      check_eq("t2f_hcnt", high_cnt, 100);

      // change duty mid-period: current period must complete unchanged
      do_load(1000, 500, "t3");
      measure(1000, 500, "t3a");
      highs = 0;
      bad   = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (i == 99) begin
            period_in = 1000;
            duty_in   = 10'd100;
            load      = 1'b1;
         end else begin
            load = 1'b0;
         end
         if (pwm_out) highs++;
         if (pwm_out !== (i < 500)) bad++;
      end
      check_eq("t3_old_high", highs, 500);
      check_eq("t3_old_shape", bad, 0);
      check_eq("t3_pend_wait", cfg_pending, 1);
      measure(1000, 100, "t3b");
      check_eq("t3_hcnt", high_cnt, 100);

      // load while busy is dropped
      enable = 1'b0;
      tick();
      period_in = 100;
      duty_in   = 10'd300;
      load      = 1'b1;
      tick();
      load = 1'b0;
      repeat (4) tick();
      duty_in = 10'd700;
      load    = 1'b1;
      tick();
      load = 1'b0;
      check_eq("t4_busy", busy, 1);
      w = 0;
      while (!cfg_pending && w < 200) begin
         tick();
         w++;
      end
      tick();
      check_eq("t4_first_only", high_cnt, 30);
      repeat (60) tick();
      check_eq("t4_no_queue", cfg_pending, 0);
      check_eq("t4_hcnt_hold", high_cnt, 30);
      do_load(100, 700, "t4b");
      tick();
      check_eq("t4b_hcnt", high_cnt, 70);

      // clamping
      do_load(1, 500, "t5p");
      tick();
      check_eq("t5p_hcnt", high_cnt, 1);
      enable = 1'b1;
      measure(2, 1, "t5pa");
      measure(2, 1, "t5pb");
      enable = 1'b0;
      tick();
      do_load(50, 1023, "t5d");
      tick();
      check_eq("t5d_hcnt", high_cnt, 50);
      enable = 1'b1;
      measure(50, 50, "t5d");
      enable = 1'b0;
      tick();
      tick();
      check_eq("t5_stop_low", pwm_out, 0);

      // randomized settings
      for (int k = 0; k < 8; k++) begin
         p  = $urandom_range(0, 60);
         d  = $urandom_range(0, 1023);
         hc = ref_hc(p, d);
         do_load(p, d, "rnd");
         tick();
         check_eq("rnd_hcnt", high_cnt, hc);
         enable = 1'b1;
         measure((p < 2) ? 2 : p, int'(hc), "rnd_a");
         measure((p < 2) ? 2 : p, int'(hc), "rnd_b");
         enable = 1'b0;
         tick();
         check_eq("rnd_stop_low", pwm_out, 0);
      end

      // reset during a divide
      period_in = 100;
      duty_in   = 10'd500;
      load      = 1'b1;
      tick();
      load = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      check_eq("r1_busy", busy, 0);
      check_eq("r1_pend", cfg_pending, 0);
      check_eq("r1_hcnt", high_cnt, 0);
      tick();
      rst_n = 1'b1;
      repeat (60) tick();
      check_eq("r1_discard", cfg_pending, 0);

      // reset during a high phase
      do_load(1000, 500, "r2");
      enable = 1'b1;
      w = 0;
      while (!period_start && w < 2100) begin
         tick();
         w++;
      end
      repeat (10) tick();
      check_eq("r2_high_before", pwm_out, 1);
      rst_n = 1'b0;
      #1;
      check_eq("r2_pwm", pwm_out, 0);
      check_eq("r2_pstart", period_start, 0);
      check_eq("r2_hcnt", high_cnt, 0);
      tick();
      rst_n = 1'b1;
      highs = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (pwm_out) highs++;
      end
      check_eq("r2_quiet", highs, 0);
      check_eq("r2_busy", busy, 0);
      check_eq("r2_pend", cfg_pending, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
